ps2_key_decoder: RTL and testbench

PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

---
 rtl/ps2_key_decoder_pkg.sv | 24 ++
 rtl/ps2_key_decoder_if.sv | 26 ++
 rtl/ps2_ascii_map.sv | 62 ++++++
 rtl/ps2_key_decoder.sv | 195 +++++++++++++++++++
 tb/tb_ps2_key_decoder.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_key_decoder_pkg.sv
// Shared constants for the PS/2 key decoder: FSM encoding, scancodes and
// counter defaults.
package ps2_key_decoder_pkg;

   localparam int unsigned BYTE_W        = 8;
   localparam int unsigned CNT_W         = 8;
   localparam int unsigned COUNT_MAX_DEF = 99;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_POP   = 2'd1,
      ST_GAP   = 2'd2,
      ST_FLUSH = 2'd3
   } state_e;

   localparam logic [BYTE_W-1:0] SC_EXT    = 8'hE0;
   localparam logic [BYTE_W-1:0] SC_BRK    = 8'hF0;
   localparam logic [BYTE_W-1:0] SC_LSHIFT = 8'h12;
   localparam logic [BYTE_W-1:0] SC_RSHIFT = 8'h59;
   localparam logic [BYTE_W-1:0] SC_CAPS   = 8'h58;
   localparam logic [BYTE_W-1:0] SC_SPACE  = 8'h29;
   localparam logic [BYTE_W-1:0] SC_ENTER  = 8'h5A;

endpackage

// File: rtl/ps2_key_decoder_if.sv
// Link between the PS/2 receiver FIFO (master) and the key decoder (slave).
//   ps2_data_i       : scancode byte at the FIFO head
//   ps2_ready_i      : FIFO non-empty, ps2_data_i valid
//   ps2_overflow_i   : FIFO overflowed
//   ps2_nextdata_n_o : active-low pop strobe from the decoder
//   ps2_clrn_o       : active-low receiver clear from the decoder
interface ps2_key_decoder_if;
   import ps2_key_decoder_pkg::*;

   logic [BYTE_W-1:0] ps2_data_i;
   logic              ps2_ready_i;
   logic              ps2_overflow_i;
   logic              ps2_nextdata_n_o;
   logic              ps2_clrn_o;

   modport master (
      output ps2_data_i, ps2_ready_i, ps2_overflow_i,
      input  ps2_nextdata_n_o, ps2_clrn_o
   );

   modport slave (
      input  ps2_data_i, ps2_ready_i, ps2_overflow_i,
      output ps2_nextdata_n_o, ps2_clrn_o
   );

endinterface

// File: rtl/ps2_ascii_map.sv
// Combinational scancode-set-2 to ASCII table (non-extended keys only).
//   code_i  : scancode without prefixes
//   ext_i   : key was E0-prefixed (always maps to 0x00)
//   upper_i : letters in uppercase
//   shift_i : a shift key is down (digits map to 0x00)
//   ascii_c : ASCII result, 0x00 when unmapped
module ps2_ascii_map
   import ps2_key_decoder_pkg::*;
(
   input  logic [BYTE_W-1:0] code_i,
   input  logic              ext_i,
   input  logic              upper_i,
   input  logic              shift_i,
   output logic [BYTE_W-1:0] ascii_c
);

   logic [BYTE_W-1:0] w_letter;
   logic [BYTE_W-1:0] w_digit;

   // Lowercase letter / digit lookup; zero means "not in this group".
   always_comb begin
      w_letter = 8'h00;
      w_digit  = 8'h00;
      case (code_i)
         8'h1C: w_letter = 8'h61;  8'h32: w_letter = 8'h62;
         8'h21: w_letter = 8'h63;  8'h23: w_letter = 8'h64;
         8'h24: w_letter = 8'h65;  8'h2B: w_letter = 8'h66;
         8'h34: w_letter = 8'h67;  8'h33: w_letter = 8'h68;
         8'h43: w_letter = 8'h69;  8'h3B: w_letter = 8'h6A;
         8'h42: w_letter = 8'h6B;  8'h4B: w_letter = 8'h6C;
         8'h3A: w_letter = 8'h6D;  8'h31: w_letter = 8'h6E;
         8'h44: w_letter = 8'h6F;  8'h4D: w_letter = 8'h70;
         8'h15: w_letter = 8'h71;  8'h2D: w_letter = 8'h72;
         8'h1B: w_letter = 8'h73;  8'h2C: w_letter = 8'h74;
         8'h3C: w_letter = 8'h75;  8'h2A: w_letter = 8'h76;
         8'h1D: w_letter = 8'h77;  8'h22: w_letter = 8'h78;
         8'h35: w_letter = 8'h79;  8'h1A: w_letter = 8'h7A;
         8'h45: w_digit  = 8'h30;  8'h16: w_digit  = 8'h31;
         8'h1E: w_digit  = 8'h32;  8'h26: w_digit  = 8'h33;
         8'h25: w_digit  = 8'h34;  8'h2E: w_digit  = 8'h35;
         8'h36: w_digit  = 8'h36;  8'h3D: w_digit  = 8'h37;
         8'h3E: w_digit  = 8'h38;  8'h46: w_digit  = 8'h39;
         default: ;
      endcase
   end

   // Apply case/shift rules; bit 5 clear turns a lowercase letter uppercase.
   always_comb begin
      ascii_c = 8'h00;
      if (!ext_i) begin
         if (w_letter != 8'h00)
            ascii_c = upper_i ? (w_letter & 8'hDF) : w_letter;
         else if (w_digit != 8'h00)
            ascii_c = shift_i ? 8'h00 : w_digit;
         else if (code_i == SC_SPACE)
            ascii_c = 8'h20;
         else if (code_i == SC_ENTER)
            ascii_c = 8'h0D;
      end
   end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 scancode stream decoder: pops bytes from the receiver FIFO, strips
// E0/F0 prefixes, tracks shift/caps/held-key state and counts new presses.
//   clk, reset    : clock, synchronous active-high reset
//   ps2           : receiver FIFO link (slave side)
//   key_valid_o   : one-cycle key event pulse
//   key_code_o    : event scancode, key_ext_o / key_break_o : prefix info
//   key_ascii_o   : ASCII of the event key (0x00 if unmapped)
//   key_held_o    : a counted key is down
//   press_count_o : new-press count, wraps after COUNT_MAX
//   caps_o        : caps-lock state
module ps2_key_decoder
   import ps2_key_decoder_pkg::*;
#(
   parameter int unsigned COUNT_MAX = COUNT_MAX_DEF
) (
   input  logic              clk,
   input  logic              reset,
   ps2_key_decoder_if.slave  ps2,
   output logic              key_valid_o,
   output logic [BYTE_W-1:0] key_code_o,
   output logic              key_ext_o,
   output logic              key_break_o,
   output logic [BYTE_W-1:0] key_ascii_o,
   output logic              key_held_o,
   output logic [CNT_W-1:0]  press_count_o,
   output logic              caps_o
);

   state_e            r_state,      w_state;
   logic [BYTE_W-1:0] r_byte,       w_byte;
   logic              r_ext,        w_ext;
   logic              r_brk,        w_brk;
   logic              r_shift_l,    w_shift_l;
   logic              r_shift_r,    w_shift_r;
   logic              r_held,       w_held;
   logic [BYTE_W-1:0] r_held_code,  w_held_code;
   logic              r_held_ext,   w_held_ext;
   logic [CNT_W-1:0]  r_count,      w_count;
   logic              r_caps,       w_caps;
   logic              r_valid,      w_valid;
   logic [BYTE_W-1:0] r_code,       w_code;
   logic              r_key_ext,    w_key_ext;
   logic              r_key_brk,    w_key_brk;
   logic [BYTE_W-1:0] r_ascii,      w_ascii;
   logic              r_nextdata_n, w_nextdata_n;
   logic              r_clrn,       w_clrn;

   logic              w_is_shift;
   logic              w_match;
   logic              w_upper;
   logic [BYTE_W-1:0] w_map_ascii;

   assign w_is_shift = !r_ext && ((r_byte == SC_LSHIFT) || (r_byte == SC_RSHIFT));
   assign w_match    = r_held && (r_held_code == r_byte) && (r_held_ext == r_ext);
   assign w_upper    = (r_shift_l | r_shift_r) ^ r_caps;

   ps2_ascii_map u_ascii_map (
      .code_i  (r_byte),
      .ext_i   (r_ext),
      .upper_i (w_upper),
      .shift_i (r_shift_l | r_shift_r),
      .ascii_c (w_map_ascii)
   );

   // State and output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= ST_IDLE;
         r_byte       <= '0;
         r_ext        <= 1'b0;
         r_brk        <= 1'b0;
         r_shift_l    <= 1'b0;
         r_shift_r    <= 1'b0;
         r_held       <= 1'b0;
         r_held_code  <= '0;
         r_held_ext   <= 1'b0;
         r_count      <= '0;
         r_caps       <= 1'b0;
         r_valid      <= 1'b0;
         r_code       <= '0;
         r_key_ext    <= 1'b0;
         r_key_brk    <= 1'b0;
         r_ascii      <= '0;
         r_nextdata_n <= 1'b1;
         r_clrn       <= 1'b0;
      end else begin
         r_state      <= w_state;
         r_byte       <= w_byte;
         r_ext        <= w_ext;
         r_brk        <= w_brk;
         r_shift_l    <= w_shift_l;
         r_shift_r    <= w_shift_r;
         r_held       <= w_held;
         r_held_code  <= w_held_code;
         r_held_ext   <= w_held_ext;
         r_count      <= w_count;
         r_caps       <= w_caps;
         r_valid      <= w_valid;
         r_code       <= w_code;
         r_key_ext    <= w_key_ext;
         r_key_brk    <= w_key_brk;
         r_ascii      <= w_ascii;
         r_nextdata_n <= w_nextdata_n;
         r_clrn       <= w_clrn;
      end
   end

   // Next-state and decode logic.
   always_comb begin
      w_state     = r_state;
      w_byte      = r_byte;
      w_ext       = r_ext;
      w_brk       = r_brk;
      w_shift_l   = r_shift_l;
      w_shift_r   = r_shift_r;
      w_held      = r_held;
      w_held_code = r_held_code;
      w_held_ext  = r_held_ext;
      w_count     = r_count;
      w_caps      = r_caps;
      w_valid     = 1'b0;
      w_code      = r_code;
      w_key_ext   = r_key_ext;
      w_key_brk   = r_key_brk;
      w_ascii     = r_ascii;

      case (r_state)
         ST_IDLE: begin
            // Overflow wins; the flush also drops any partial prefix sequence.
            if (ps2.ps2_overflow_i) begin
               w_state   = ST_FLUSH;
               w_ext     = 1'b0;
               w_brk     = 1'b0;
               w_held    = 1'b0;
               w_shift_l = 1'b0;
               w_shift_r = 1'b0;
            end else if (ps2.ps2_ready_i) begin
               w_byte  = ps2.ps2_data_i;
               w_state = ST_POP;
            end
         end
         ST_POP: begin
            w_state = ST_GAP;
            if (r_byte == SC_EXT) begin
               w_ext = 1'b1;
            end else if (r_byte == SC_BRK) begin
               w_brk = 1'b1;
            end else begin
               w_valid   = 1'b1;
               w_code    = r_byte;
               w_key_ext = r_ext;
               w_key_brk = r_brk;
               w_ascii   = w_map_ascii;
               w_ext     = 1'b0;
               w_brk     = 1'b0;
               if (w_is_shift) begin
                  if (r_byte == SC_LSHIFT) w_shift_l = !r_brk;
                  else                     w_shift_r = !r_brk;
               end else if (!r_brk) begin
                  // A make matching the held key is typematic repeat.
                  if (!w_match) begin
                     if (!r_ext && (r_byte == SC_CAPS)) w_caps = !r_caps;
                     w_count     = (r_count == CNT_W'(COUNT_MAX)) ? '0
                                                                  : r_count + CNT_W'(1);
                     w_held_code = r_byte;
                     w_held_ext  = r_ext;
                     w_held      = 1'b1;
                  end
               end else if (w_match) begin
                  w_held = 1'b0;
               end
            end
         end
         ST_GAP:   w_state = ST_IDLE;
         ST_FLUSH: w_state = ST_IDLE;
         default:  w_state = ST_IDLE;
      endcase

      // Strobes are registered from the state being entered.
      w_nextdata_n = (w_state != ST_POP);
      w_clrn       = (w_state != ST_FLUSH);
   end

   assign ps2.ps2_nextdata_n_o = r_nextdata_n;
   assign ps2.ps2_clrn_o       = r_clrn;
   assign key_valid_o          = r_valid;
   assign key_code_o           = r_code;
   assign key_ext_o            = r_key_ext;
   assign key_break_o          = r_key_brk;
   assign key_ascii_o          = r_ascii;
   assign key_held_o           = r_held;
   assign press_count_o        = r_count;
   assign caps_o               = r_caps;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: drives a simple FIFO-head model and
// checks event outputs against hand-computed values.
module tb_ps2_key_decoder;

   logic       clk;
   logic       reset;
   logic       key_valid_o;
   logic [7:0] key_code_o;
   logic       key_ext_o;
   logic       key_break_o;
   logic [7:0] key_ascii_o;
   logic       key_held_o;
   logic [7:0] press_count_o;
   logic       caps_o;

   int n_checks = 0;
   int n_errors = 0;
   int n_pulses = 0;

   ps2_key_decoder_if ps2_bus ();

   ps2_key_decoder #(.COUNT_MAX(99)) dut (
      .clk           (clk),
      .reset         (reset),
      .ps2           (ps2_bus),
      .key_valid_o   (key_valid_o),
      .key_code_o    (key_code_o),
      .key_ext_o     (key_ext_o),
      .key_break_o   (key_break_o),
      .key_ascii_o   (key_ascii_o),
      .key_held_o    (key_held_o),
      .press_count_o (press_count_o),
      .caps_o        (caps_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) if (key_valid_o === 1'b1) n_pulses++;

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Present a byte at the FIFO head, wait for the pop, return in GAP.
   task automatic send_byte(input logic [7:0] b);
      bit popped = 1'b0;
      ps2_bus.ps2_data_i  = b;
      ps2_bus.ps2_ready_i = 1'b1;
      for (int i = 0; i < 20 && !popped; i++) begin
         @(posedge clk); #1;
         if (ps2_bus.ps2_nextdata_n_o === 1'b0) popped = 1'b1;
      end
      check("pop_seen", 32'(popped), 32'd1);
      ps2_bus.ps2_ready_i = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      reset                  = 1'b1;
      ps2_bus.ps2_ready_i    = 1'b0;
      ps2_bus.ps2_overflow_i = 1'b0;
      ps2_bus.ps2_data_i     = 8'h00;
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
   endtask

   initial begin
      int snap;
      bit saw_pop;
      bit saw_clr;

      // Reset values while reset is held
      reset                  = 1'b1;
      ps2_bus.ps2_ready_i    = 1'b0;
      ps2_bus.ps2_overflow_i = 1'b0;
      ps2_bus.ps2_data_i     = 8'h00;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("rst_nextdata_n", ps2_bus.ps2_nextdata_n_o, 1);
      check("rst_clrn",       ps2_bus.ps2_clrn_o, 0);
      check("rst_valid",      key_valid_o, 0);
      check("rst_code",       key_code_o, 0);
      check("rst_ext_brk",    {key_ext_o, key_break_o}, 0);
      check("rst_ascii",      key_ascii_o, 0);
      check("rst_held",       key_held_o, 0);
      check("rst_count",      press_count_o, 0);
      check("rst_caps",       caps_o, 0);
      reset = 1'b0;
      @(posedge clk); #1;
      check("post_rst_clrn",  ps2_bus.ps2_clrn_o, 1);

      // Make then break of 'a'
      send_byte(8'h1C);
      check("a_valid", key_valid_o, 1);
      check("a_code",  key_code_o, 8'h1C);
      check("a_brk",   key_break_o, 0);
      check("a_ascii", key_ascii_o, 8'h61);
      check("a_count", press_count_o, 1);
      check("a_held",  key_held_o, 1);
      @(posedge clk); #1;
      check("a_pulse_one_cycle", key_valid_o, 0);
      send_byte(8'hF0);
      check("f0_no_event", key_valid_o, 0);
      send_byte(8'h1C);
      check("ab_valid", key_valid_o, 1);
      check("ab_brk",   key_break_o, 1);
      check("ab_ascii", key_ascii_o, 8'h61);
      check("ab_held",  key_held_o, 0);
      check("ab_count", press_count_o, 1);

      // Typematic repeat
      do_reset();
      snap = n_pulses;
      send_byte(8'h1C); send_byte(8'h1C); send_byte(8'h1C);
      send_byte(8'hF0); send_byte(8'h1C);
      @(posedge clk); #1;
      check("rep_pulses", n_pulses - snap, 4);
      check("rep_count",  press_count_o, 1);
      check("rep_held",   key_held_o, 0);

      // Shift / caps handling
      do_reset();
      send_byte(8'h12);
      check("sh_valid", key_valid_o, 1);
      check("sh_count", press_count_o, 0);
      check("sh_held",  key_held_o, 0);
      send_byte(8'h1C);
      check("sh_a_ascii", key_ascii_o, 8'h41);
      send_byte(8'hF0); send_byte(8'h12);
      check("shb_brk",   key_break_o, 1);
      check("shb_held",  key_held_o, 1);
      send_byte(8'h58);
      check("caps_on",    caps_o, 1);
      check("caps_ascii", key_ascii_o, 8'h00);
      send_byte(8'h1C);
      check("caps_a_ascii", key_ascii_o, 8'h41);
      check("caps_count",   press_count_o, 3);
      send_byte(8'h12);
      send_byte(8'h1C);
      check("caps_shift_a", key_ascii_o, 8'h61);
      check("caps_shift_rep_count", press_count_o, 3);
      send_byte(8'h16);
      check("shift_digit", key_ascii_o, 8'h00);
      send_byte(8'hF0); send_byte(8'h12);
      send_byte(8'h16);
      check("digit_1",     key_ascii_o, 8'h31);
      send_byte(8'h29);
      check("space",       key_ascii_o, 8'h20);
      send_byte(8'h5A);
      check("enter",       key_ascii_o, 8'h0D);
      check("shift_count", press_count_o, 6);
      check("caps_still",  caps_o, 1);

      // Extended key
      do_reset();
      send_byte(8'hE0);
      check("e0_no_event", key_valid_o, 0);
      send_byte(8'h75);
      check("ext_valid", key_valid_o, 1);
      check("ext_flags", {key_ext_o, key_break_o}, 2'b10);
      check("ext_ascii", key_ascii_o, 8'h00);
      check("ext_held",  key_held_o, 1);
      send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
      check("extb_flags", {key_ext_o, key_break_o}, 2'b11);
      check("extb_held",  key_held_o, 0);
      send_byte(8'h1C);
      check("flags_cleared", {key_ext_o, key_break_o}, 2'b00);
      send_byte(8'hF0); send_byte(8'h1D);
      check("nonmatch_brk_held", key_held_o, 1);

      // Counter wrap
      do_reset();
      for (int i = 0; i < 99; i++) begin
         send_byte(8'h1C); send_byte(8'hF0); send_byte(8'h1C);
      end
      check("count_99", press_count_o, 99);
      send_byte(8'h1C);
      check("count_wrap", press_count_o, 0);
      check("wrap_held",  key_held_o, 1);

      // Overflow while idle, with ready also high
      ps2_bus.ps2_data_i     = 8'h1C;
      ps2_bus.ps2_ready_i    = 1'b1;
      ps2_bus.ps2_overflow_i = 1'b1;
      saw_pop = 1'b0;
      saw_clr = 1'b0;
      for (int i = 0; i < 10 && !saw_clr; i++) begin
         @(posedge clk); #1;
         if (ps2_bus.ps2_nextdata_n_o === 1'b0) saw_pop = 1'b1;
         if (ps2_bus.ps2_clrn_o === 1'b0) saw_clr = 1'b1;
      end
      ps2_bus.ps2_overflow_i = 1'b0;
      ps2_bus.ps2_ready_i    = 1'b0;
      check("ovf_clr_seen", 32'(saw_clr), 1);
      @(posedge clk); #1;
      check("ovf_clr_one_cycle", ps2_bus.ps2_clrn_o, 1);
      check("ovf_no_pop", 32'(saw_pop), 0);
      check("ovf_held",   key_held_o, 0);

      // Overflow arriving during POP is handled after the byte is decoded
      ps2_bus.ps2_data_i  = 8'h1D;
      ps2_bus.ps2_ready_i = 1'b1;
      saw_pop = 1'b0;
      for (int i = 0; i < 10 && !saw_pop; i++) begin
         @(posedge clk); #1;
         if (ps2_bus.ps2_nextdata_n_o === 1'b0) saw_pop = 1'b1;
      end
      check("pop_ovf_pop_seen", 32'(saw_pop), 1);
      ps2_bus.ps2_ready_i    = 1'b0;
      ps2_bus.ps2_overflow_i = 1'b1;
      @(posedge clk); #1;
      check("pop_ovf_valid", key_valid_o, 1);
      check("pop_ovf_code",  key_code_o, 8'h1D);
      check("pop_ovf_clrn_gap", ps2_bus.ps2_clrn_o, 1);
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("pop_ovf_clrn", ps2_bus.ps2_clrn_o, 0);
      ps2_bus.ps2_overflow_i = 1'b0;
      @(posedge clk); #1;
      check("pop_ovf_held", key_held_o, 0);

      // Reset during POP
      send_byte(8'h58);
      check("pre_rst_caps", caps_o, 1);
      ps2_bus.ps2_data_i  = 8'h1C;
      ps2_bus.ps2_ready_i = 1'b1;
      saw_pop = 1'b0;
      for (int i = 0; i < 10 && !saw_pop; i++) begin
         @(posedge clk); #1;
         if (ps2_bus.ps2_nextdata_n_o === 1'b0) saw_pop = 1'b1;
      end
      check("rpop_pop_seen", 32'(saw_pop), 1);
      snap = n_pulses;
      reset               = 1'b1;
      ps2_bus.ps2_ready_i = 1'b0;
      @(posedge clk); #1;
      check("rpop_nextdata_n", ps2_bus.ps2_nextdata_n_o, 1);
      check("rpop_clrn",   ps2_bus.ps2_clrn_o, 0);
      check("rpop_valid",  key_valid_o, 0);
      check("rpop_code",   key_code_o, 0);
      check("rpop_ascii",  key_ascii_o, 0);
      check("rpop_count",  press_count_o, 0);
      check("rpop_caps",   caps_o, 0);
      check("rpop_held",   key_held_o, 0);
      reset = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check("rpop_byte_lost", n_pulses - snap, 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
